// File: rtl/dft_result_collector_if.sv
// Stream bundle between the DFT core, the result collector and the
// downstream pitch-analysis logic. The collector uses the slave modport;
// the producer/consumer side uses the master modport.
interface dft_result_collector_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10,
    parameter int EXP_W  = 4
);
    logic [ADDR_W:0]          FRAME_LEN;
    logic signed [DATA_W-1:0] XK_RE;
    logic signed [DATA_W-1:0] XK_IM;
    logic [EXP_W-1:0]         BLK_EXP;
    logic                     DATA_VALID;
    logic                     IN_READY;
    logic [2*DATA_W:0]        OUT_DATA;
    logic [ADDR_W-1:0]        OUT_INDEX;
    logic [EXP_W-1:0]         OUT_EXP;
    logic                     OUT_LAST;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic                     OVERFLOW;
    logic                     OVF_CLR;

    modport master (
        output FRAME_LEN, XK_RE, XK_IM, BLK_EXP, DATA_VALID, OUT_READY, OVF_CLR,
        input  IN_READY, OUT_DATA, OUT_INDEX, OUT_EXP, OUT_LAST, OUT_VALID, OVERFLOW
    );

    modport slave (
        input  FRAME_LEN, XK_RE, XK_IM, BLK_EXP, DATA_VALID, OUT_READY, OVF_CLR,
        output IN_READY, OUT_DATA, OUT_INDEX, OUT_EXP, OUT_LAST, OUT_VALID, OVERFLOW
    );
endinterface

// File: rtl/dft_result_collector.sv
// DFT result collector: squares each incoming bin (re^2 + im^2) through a
// two-stage pipeline into a frame buffer, then drains the frame in bin
// order over a valid/ready stream with a prefetch register so a held-high
// OUT_READY sees one beat per cycle.
module dft_result_collector #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10,
    parameter int EXP_W  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    dft_result_collector_if.slave  bus
);
    localparam int PW    = 2 * DATA_W + 1;
    localparam int MW    = 2 * DATA_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W:0]        in_cnt_q, in_cnt_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]      s1_idx_q, s1_idx_d;
    logic signed [MW-1:0]   rr_q, rr_d;
    logic signed [MW-1:0]   ii_q, ii_d;
    logic                   ovf_q, ovf_d;
    logic [ADDR_W:0]        rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]        rd_tag_q, rd_tag_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [PW-1:0]          rd_data_q;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [PW-1:0]          out_data_q, out_data_d;
    logic [ADDR_W-1:0]      out_index_q, out_index_d;

    logic [PW-1:0]          mem [DEPTH];

    logic                   accept_s;
    logic                   drop_s;
    logic [ADDR_W:0]        frame_len_s;
    logic                   pop_s;
    logic                   out_load_s;
    logic                   issue_s;
    logic [PW-1:0]          psum_s;
    logic signed [MW-1:0]   rr_s;
    logic signed [MW-1:0]   ii_s;

    // Squares are always non-negative, so zero-extending them makes the sum exact.
    assign rr_s   = $signed(bus.XK_RE) * $signed(bus.XK_RE);
    assign ii_s   = $signed(bus.XK_IM) * $signed(bus.XK_IM);
    assign psum_s = {1'b0, rr_q} + {1'b0, ii_q};

    assign accept_s = bus.DATA_VALID && ((state_q == S_IDLE) || (state_q == S_COLLECT));
    assign drop_s   = bus.DATA_VALID && ((state_q == S_FLUSH) || (state_q == S_DRAIN));
    assign frame_len_s = ((bus.FRAME_LEN == {(ADDR_W+1){1'b0}}) || (bus.FRAME_LEN > MAX_N))
                         ? MAX_N : bus.FRAME_LEN;

    // The read slot refills whenever its word moves to the output register.
    assign pop_s      = out_valid_q && bus.OUT_READY;
    assign out_load_s = rd_vld_q && (!out_valid_q || pop_s);
    assign issue_s    = (state_q == S_DRAIN) && (rd_addr_q < len_q) && (!rd_vld_q || out_load_s);

    // Frame sequencing: collect, wait for the last write, drain, back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (frame_len_s == ONE_L) ? S_FLUSH : S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (accept_s && (in_cnt_q == (len_q - ONE_L))) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_FLUSH: begin
                if (!s1_vld_q) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (pop_s && out_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Input side: frame length/exponent latch, bin counter, square stage, overflow flag.
    always_comb begin
        len_d    = len_q;
        in_cnt_d = in_cnt_q;
        exp_d    = exp_q;
        s1_vld_d = accept_s;
        s1_idx_d = (state_q == S_IDLE) ? {ADDR_W{1'b0}} : in_cnt_q[ADDR_W-1:0];
        rr_d     = rr_s;
        ii_d     = ii_s;
        if (accept_s && (state_q == S_IDLE)) begin
            len_d    = frame_len_s;
            in_cnt_d = ONE_L;
            exp_d    = bus.BLK_EXP;
        end else if (accept_s) begin
            in_cnt_d = in_cnt_q + ONE_L;
        end else begin
            in_cnt_d = in_cnt_q;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Drain side: read issue, prefetch slot and output register.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        rd_tag_d    = rd_tag_q;
        rd_vld_d    = rd_vld_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        if (state_q != S_DRAIN) begin
            rd_addr_d = {(ADDR_W+1){1'b0}};
        end else if (issue_s) begin
            rd_addr_d = rd_addr_q + ONE_L;
        end else begin
            rd_addr_d = rd_addr_q;
        end
        if (issue_s) begin
            rd_vld_d = 1'b1;
            rd_tag_d = rd_addr_q;
        end else if (out_load_s) begin
            rd_vld_d = 1'b0;
        end else begin
            rd_vld_d = rd_vld_q;
        end
        if (out_load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            out_index_d = rd_tag_q[ADDR_W-1:0];
            out_last_d  = (rd_tag_q == (len_q - ONE_L));
        end else if (pop_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            len_q       <= {(ADDR_W+1){1'b0}};
            in_cnt_q    <= {(ADDR_W+1){1'b0}};
            exp_q       <= {EXP_W{1'b0}};
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= {ADDR_W{1'b0}};
            rr_q        <= {MW{1'b0}};
            ii_q        <= {MW{1'b0}};
            ovf_q       <= 1'b0;
            rd_addr_q   <= {(ADDR_W+1){1'b0}};
            rd_tag_q    <= {(ADDR_W+1){1'b0}};
            rd_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {PW{1'b0}};
            out_index_q <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            in_cnt_q    <= in_cnt_d;
            exp_q       <= exp_d;
            s1_vld_q    <= s1_vld_d;
            s1_idx_q    <= s1_idx_d;
            rr_q        <= rr_d;
            ii_q        <= ii_d;
            ovf_q       <= ovf_d;
            rd_addr_q   <= rd_addr_d;
            rd_tag_q    <= rd_tag_d;
            rd_vld_q    <= rd_vld_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
        end
    end

    // Frame buffer: second pipeline stage writes the power, drain reads synchronously.
    always_ff @(posedge CLK) begin
        if (s1_vld_q) begin
            mem[s1_idx_q] <= psum_s;
        end
        if (issue_s) begin
            rd_data_q <= mem[rd_addr_q[ADDR_W-1:0]];
        end
    end

    assign bus.IN_READY  = (state_q == S_IDLE);
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_INDEX = out_index_q;
    assign bus.OUT_EXP   = exp_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_dft_result_collector.sv
// Directed bench for dft_result_collector: frames are driven on the falling
// edge, outputs are sampled on the falling edge, and every drained beat is
// compared with a power value computed by the bench.
module tb_dft_result_collector;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;
    localparam int EXP_W  = 4;

    logic clk;
    logic rst_n;

    int     checks;
    int     failures;
    int     re_a [1024];
    int     im_a [1024];
    longint exp_pw [1024];
    int     tog_p [5];

    dft_result_collector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXP_W(EXP_W)) bus ();

    dft_result_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXP_W(EXP_W)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model of the collector's arithmetic for the bench-generated frames.
    function automatic longint power_of(input int re, input int im);
        return longint'(re) * longint'(re) + longint'(im) * longint'(im);
    endfunction

    // Waits for IN_READY, then drives n samples; gap_mode inserts i%4 idle cycles.
    task automatic send_frame(input int flen, input int n, input int bexp, input int gap_mode);
        int waited;
        waited = 0;
        while (!bus.IN_READY && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("in_ready_before_frame", bus.IN_READY, 1);
        bus.FRAME_LEN = flen[ADDR_W:0];
        bus.BLK_EXP   = bexp[EXP_W-1:0];
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < ((gap_mode != 0) ? (i % 4) : 0); g++) begin
                bus.DATA_VALID = 1'b0;
                @(negedge clk);
            end
            bus.XK_RE      = re_a[i][DATA_W-1:0];
            bus.XK_IM      = im_a[i][DATA_W-1:0];
            bus.DATA_VALID = 1'b1;
            @(negedge clk);
            bus.DATA_VALID = 1'b0;
            bus.BLK_EXP    = 4'd15;
        end
    endtask

    // Drains n beats; mode 0 ready high, 1 toggling pattern, 2 random ready.
    task automatic drain(input int n, input int bexp, input int mode);
        int beats;
        int cyc;
        int first_cyc;
        int last_cyc;
        bit done;
        beats = 0;
        done = 1'b0;
        first_cyc = 0;
        last_cyc = 0;
        cyc = 0;
        while (!done && cyc < n * 10 + 50) begin
            if (mode == 0)      bus.OUT_READY = 1'b1;
            else if (mode == 1) bus.OUT_READY = tog_p[cyc % 5][0];
            else                bus.OUT_READY = 1'($urandom_range(0, 1));
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                check_eq("beat_index", bus.OUT_INDEX, beats);
                check_eq("beat_data", bus.OUT_DATA, exp_pw[beats]);
                check_eq("beat_last", bus.OUT_LAST, (beats == n - 1) ? 1 : 0);
                check_eq("beat_exp", bus.OUT_EXP, bexp);
                beats++;
                if (bus.OUT_LAST || beats >= n) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("beat_count", beats, n);
        if (mode == 0) check_eq("beats_back_to_back", last_cyc - first_cyc, n - 1);
        check_eq("valid_low_after_last", bus.OUT_VALID, 0);
        check_eq("in_ready_after_last", bus.IN_READY, 1);
        bus.OUT_READY = 1'b0;
    endtask

    // Loads the four-bin reference frame with hand-computed powers.
    task automatic load_frame_a();
        re_a[0] = 1;  im_a[0] = 0;       exp_pw[0] = 64'd1;
        re_a[1] = 2;  im_a[1] = 2;       exp_pw[1] = 64'd8;
        re_a[2] = -3; im_a[2] = 4;       exp_pw[2] = 64'd25;
        re_a[3] = 0;  im_a[3] = -131072; exp_pw[3] = 64'd17179869184;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        tog_p[0] = 1; tog_p[1] = 0; tog_p[2] = 0; tog_p[3] = 1; tog_p[4] = 0;
        rst_n          = 1'b0;
        bus.FRAME_LEN  = '0;
        bus.XK_RE      = '0;
        bus.XK_IM      = '0;
        bus.BLK_EXP    = '0;
        bus.DATA_VALID = 1'b0;
        bus.OUT_READY  = 1'b0;
        bus.OVF_CLR    = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", bus.IN_READY, 1);
        check_eq("rst_out_valid", bus.OUT_VALID, 0);
        check_eq("rst_out_last", bus.OUT_LAST, 0);
        check_eq("rst_out_data", bus.OUT_DATA, 0);
        check_eq("rst_out_index", bus.OUT_INDEX, 0);
        check_eq("rst_out_exp", bus.OUT_EXP, 0);
        check_eq("rst_overflow", bus.OVERFLOW, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a frame is stalled in DRAIN.
        load_frame_a();
        send_frame(4, 4, 3, 0);
        repeat (6) @(negedge clk);
        check_eq("stall_valid_before_rst", bus.OUT_VALID, 1);
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        check_eq("ovf_before_rst", bus.OVERFLOW, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", bus.OUT_VALID, 0);
        check_eq("midrst_in_ready", bus.IN_READY, 1);
        check_eq("midrst_overflow", bus.OVERFLOW, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference frame, ready held high.
        send_frame(4, 4, 3, 0);
        drain(4, 3, 0);

        // Reference frame, toggling ready.
        send_frame(4, 4, 3, 0);
        drain(4, 3, 1);

        // Eight bins with input gaps, random ready.
        for (int i = 0; i < 8; i++) begin
            re_a[i] = 1000 * i - 3000;
            im_a[i] = 131071 - 7 * i;
            exp_pw[i] = power_of(re_a[i], im_a[i]);
        end
        send_frame(8, 8, 9, 1);
        drain(8, 9, 2);

        // Out-of-range lengths fall back to the full buffer.
        for (int i = 0; i < 1024; i++) begin
            re_a[i] = ((i * 37) % 2000) - 1000;
            im_a[i] = 131071 - 100 * i;
            exp_pw[i] = power_of(re_a[i], im_a[i]);
        end
        re_a[5] = -131072;
        exp_pw[5] = power_of(re_a[5], im_a[5]);
        send_frame(0, 1024, 7, 0);
        drain(1024, 7, 0);
        send_frame(2000, 1024, 2, 0);
        drain(1024, 2, 0);

        // Single-bin frame.
        re_a[0] = 5; im_a[0] = -5; exp_pw[0] = 64'd50;
        send_frame(1, 1, 1, 0);
        drain(1, 1, 0);

        // Drops during FLUSH/DRAIN and OVERFLOW clear behaviour.
        load_frame_a();
        send_frame(4, 4, 3, 0);
        repeat (2) @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.XK_RE = 18'sd100;
        bus.XK_IM = 18'sd100;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        check_eq("ovf_set_on_drop", bus.OVERFLOW, 1);
        bus.DATA_VALID = 1'b1;
        bus.OVF_CLR = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        bus.OVF_CLR = 1'b0;
        check_eq("ovf_set_beats_clear", bus.OVERFLOW, 1);
        bus.OVF_CLR = 1'b1;
        @(negedge clk);
        bus.OVF_CLR = 1'b0;
        check_eq("ovf_cleared", bus.OVERFLOW, 0);
        drain(4, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
